// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline control slice.
//                Holds the stall/flush FSM encoding, the register-file depth
//                and the NOP instruction that flush consumers write into
//                IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int          REGFILE_LOG2_DEEP = 5;
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;   // addi x0,x0,0

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at MAX_VAL instead of wrapping.
//                clear has priority over inc.
//  Ports       : clk, reset (sync, active-high), inc, clear, count[WIDTH-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != MAX_VAL)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Converts the decode RAW hazard and the EX-stage redirect
//                into PC/IF-ID/ID-EX controls. Priority per cycle is
//                freeze > redirect > hazard. Keeps saturating stall and
//                flush event counters plus a sticky stall watchdog.
//  Ports       : clk, reset            clock, sync active-high reset
//                hazard_i              decode RAW hazard (level)
//                redirect_i            EX taken branch/JAL/JALR (pulse)
//                freeze_i              external front-end halt
//                pc_we_o, ifid_we_o    write enables
//                ifid_flush_o          IF/ID cleared to NOP
//                idex_bubble_o         ID/EX control zeroed
//                stall_cnt_o           saturating hazard-stall cycle count
//                flush_cnt_o           saturating redirect count
//                wdog_err_o            sticky: stall run exceeded MAX_STALL
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MAX_STALL    = 15,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hazard_i,
   input  logic                 redirect_i,
   input  logic                 freeze_i,
   output logic                 pc_we_o,
   output logic                 ifid_we_o,
   output logic                 ifid_flush_o,
   output logic                 idex_bubble_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o,
   output logic                 wdog_err_o
);

   // Run-length counter must be able to hold MAX_STALL+1.
   localparam int              RL_W          = $clog2(MAX_STALL + 2);
   localparam logic [RL_W-1:0] c_run_max     = RL_W'(MAX_STALL + 1);
   localparam logic [RL_W-1:0] c_wdog_pre    = RL_W'(MAX_STALL);
   localparam logic [1:0]      c_flush_init  = 2'(FLUSH_CYCLES - 1);

   state_t          r_state;
   logic [1:0]      r_fcnt;
   logic            r_pend;
   logic            r_wdog;
   logic [RL_W-1:0] w_run_len;

   logic w_redir;
   logic w_in_flush;
   logic w_take_redir;
   logic w_take_stall;
   logic w_run_clear;

   // A redirect seen while frozen is remembered and serviced later.
   assign w_redir      = redirect_i | r_pend;
   assign w_in_flush   = (r_state == ST_FLUSH);
   assign w_take_redir = !freeze_i & w_redir;
   // Hazards are meaningless in FLUSH: the decode instruction is wrong-path.
   assign w_take_stall = !freeze_i & !w_redir & !w_in_flush & hazard_i;
   assign w_run_clear  = !freeze_i & !w_take_stall;

   // Outputs depend on current inputs so a hazard stalls in its own cycle.
   always_comb begin
      pc_we_o       = 1'b1;
      ifid_we_o     = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      if (freeze_i) begin
         pc_we_o   = 1'b0;
         ifid_we_o = 1'b0;
      end else if (w_redir || w_in_flush) begin
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (hazard_i) begin
         pc_we_o       = 1'b0;
         ifid_we_o     = 1'b0;
         idex_bubble_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_fcnt  <= 2'd0;
         r_pend  <= 1'b0;
         r_wdog  <= 1'b0;
      end else begin
         if (freeze_i) begin
            if (redirect_i) begin
               r_pend <= 1'b1;
            end
         end else if (w_redir) begin
            r_pend  <= 1'b0;
            r_fcnt  <= c_flush_init;
            r_state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
         end else if (w_in_flush) begin
            r_fcnt <= r_fcnt - 2'd1;
            if (r_fcnt <= 2'd1) begin
               r_state <= ST_RUN;
            end
         end else if (hazard_i) begin
            r_state <= ST_STALL;
         end else begin
            r_state <= ST_RUN;
         end

         // Set on the same edge the run-length counter reaches MAX_STALL+1.
         if (w_take_stall && (w_run_len == c_wdog_pre)) begin
            r_wdog <= 1'b1;
         end
      end
   end

   assign wdog_err_o = r_wdog;

   sat_counter #(
      .WIDTH   (CNT_WIDTH)
   ) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_take_stall),
      .clear   (1'b0),
      .count   (stall_cnt_o)
   );

   sat_counter #(
      .WIDTH   (CNT_WIDTH)
   ) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_take_redir),
      .clear   (1'b0),
      .count   (flush_cnt_o)
   );

   sat_counter #(
      .WIDTH   (RL_W),
      .MAX_VAL (c_run_max)
   ) u_run_len (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_take_stall),
      .clear   (w_run_clear),
      .count   (w_run_len)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_ctrl
//  Description : Self-checking bench for pipeline_stall_ctrl with directed
//                scenarios and a randomized run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

   localparam int FC   = 2;
   localparam int MS   = 15;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          hazard_i, redirect_i, freeze_i;
   logic          pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;
   logic          wdog_err_o;
   logic [3:0]    ctl;

   assign ctl = {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o};

   pipeline_stall_ctrl #(
      .FLUSH_CYCLES (FC),
      .MAX_STALL    (MS),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .hazard_i      (hazard_i),
      .redirect_i    (redirect_i),
      .freeze_i      (freeze_i),
      .pc_we_o       (pc_we_o),
      .ifid_we_o     (ifid_we_o),
      .ifid_flush_o  (ifid_flush_o),
      .idex_bubble_o (idex_bubble_o),
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
      .wdog_err_o    (wdog_err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: remaining flush cycles, current stall run length,
   // pending redirect, event totals.
   int   m_flush_left, m_run, m_stall, m_flush;
   bit   m_pend, m_wdog;
   bit   a_h, a_r, a_f;
   logic [3:0] exp_ctl;

   task automatic model_reset();
      m_flush_left = 0; m_run = 0; m_stall = 0; m_flush = 0;
      m_pend = 0; m_wdog = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; hazard_i = 1'b0; redirect_i = 1'b0; freeze_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // Drive one cycle's inputs and predict the combinational controls.
   task automatic apply(input bit h, input bit r, input bit f);
      hazard_i = h; redirect_i = r; freeze_i = f;
      a_h = h; a_r = r; a_f = f;
      if (f)                   exp_ctl = 4'b0000;
      else if (r || m_pend)    exp_ctl = 4'b1111;
      else if (m_flush_left>0) exp_ctl = 4'b1111;
      else if (h)              exp_ctl = 4'b0001;
      else                     exp_ctl = 4'b1100;
      #1;
   endtask

   // Advance one clock and update the model with the applied inputs.
   task automatic tick();
      @(posedge clk);
      if (a_f) begin
         if (a_r) m_pend = 1;
      end else if (a_r || m_pend) begin
         m_pend = 0;
         m_flush_left = FC - 1;
         m_run = 0;
         if (m_flush < CMAX) m_flush++;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
         m_run = 0;
      end else if (a_h) begin
         if (m_stall < CMAX) m_stall++;
         if (m_run < MS + 1) m_run++;
         if (m_run == MS + 1) m_wdog = 1;
      end else begin
         m_run = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      apply(0, 0, 0);
      n_checks++;
      if (ctl !== 4'b1100) begin
         n_errors++; $display("FAIL reset_ctl: got %b want 1100", ctl);
      end
      n_checks++;
      if ({stall_cnt_o, flush_cnt_o, wdog_err_o} !== {CW'(0), CW'(0), 1'b0}) begin
         n_errors++;
         $display("FAIL reset_regs: stall=%0d flush=%0d wdog=%b want 0 0 0",
                  stall_cnt_o, flush_cnt_o, wdog_err_o);
      end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 0);
         n_checks++;
         if (ctl !== 4'b0001) begin
            n_errors++; $display("FAIL stall_ctl cyc%0d: got %b want 0001", i, ctl);
         end
         tick();
      end
      apply(0, 0, 0);
      n_checks++;
      if (ctl !== 4'b1100) begin
         n_errors++; $display("FAIL stall_release: got %b want 1100", ctl);
      end
      n_checks++;
      if (stall_cnt_o !== CW'(3)) begin
         n_errors++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(0, (i == 0), 0);
         n_checks++;
         if (ctl !== ((i < FC) ? 4'b1111 : 4'b1100)) begin
            n_errors++;
            $display("FAIL flush_ctl cyc%0d: got %b want %b", i, ctl,
                     (i < FC) ? 4'b1111 : 4'b1100);
         end
         tick();
      end
      n_checks++;
      if (flush_cnt_o !== CW'(1)) begin
         n_errors++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt_o);
      end
   endtask

   task automatic test_redirect_hazard();
      do_reset();
      apply(1, 1, 0);
      n_checks++;
      if (ctl !== 4'b1111) begin
         n_errors++; $display("FAIL redir_hazard_ctl: got %b want 1111", ctl);
      end
      tick();
      apply(1, 0, 0);   // hazard ignored during the remaining flush cycle
      n_checks++;
      if (ctl !== 4'b1111) begin
         n_errors++; $display("FAIL flush_ignores_hazard: got %b want 1111", ctl);
      end
      tick();
      n_checks++;
      if ({stall_cnt_o, flush_cnt_o} !== {CW'(0), CW'(1)}) begin
         n_errors++;
         $display("FAIL redir_hazard_cnt: stall=%0d flush=%0d want 0 1",
                  stall_cnt_o, flush_cnt_o);
      end
      apply(1, 0, 0);
      n_checks++;
      if (ctl !== 4'b0001) begin
         n_errors++; $display("FAIL post_flush_stall: got %b want 0001", ctl);
      end
      tick();
   endtask

   task automatic test_freeze();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1, (i == 1), 1);
         n_checks++;
         if (ctl !== 4'b0000) begin
            n_errors++; $display("FAIL freeze_ctl cyc%0d: got %b want 0000", i, ctl);
         end
         tick();
      end
      n_checks++;
      if ({stall_cnt_o, flush_cnt_o} !== {CW'(0), CW'(0)}) begin
         n_errors++;
         $display("FAIL freeze_cnt: stall=%0d flush=%0d want 0 0",
                  stall_cnt_o, flush_cnt_o);
      end
      apply(1, 0, 0);
      n_checks++;
      if (ctl !== 4'b1111) begin
         n_errors++; $display("FAIL pending_redirect: got %b want 1111", ctl);
      end
      tick();
      n_checks++;
      if (flush_cnt_o !== CW'(1)) begin
         n_errors++; $display("FAIL pending_flush_cnt: got %0d want 1", flush_cnt_o);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         apply(1, 0, 0);
         tick();
         if (i == MS || i == MS + 1) begin
            n_checks++;
            if (wdog_err_o !== (i == MS + 1)) begin
               n_errors++;
               $display("FAIL wdog after %0d stalls: got %b want %b",
                        i, wdog_err_o, (i == MS + 1));
            end
         end
      end
      n_checks++;
      if (stall_cnt_o !== CW'(CMAX)) begin
         n_errors++; $display("FAIL stall_saturate: got %0d want %0d", stall_cnt_o, CMAX);
      end
      apply(0, 0, 0);
      tick();
      n_checks++;
      if (wdog_err_o !== 1'b1) begin
         n_errors++; $display("FAIL wdog_sticky: got %b want 1", wdog_err_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      apply(0, 1, 0);
      tick();
      do_reset();   // reset while the flush is still in progress
      apply(0, 0, 0);
      n_checks++;
      if (ctl !== 4'b1100) begin
         n_errors++; $display("FAIL reset_mid_flush: got %b want 1100", ctl);
      end
      tick();
      apply(1, 0, 0); tick();
      apply(1, 0, 0); tick();
      do_reset();   // reset mid-stall
      apply(0, 0, 0);
      n_checks++;
      if ({ctl, stall_cnt_o} !== {4'b1100, CW'(0)}) begin
         n_errors++;
         $display("FAIL reset_mid_stall: ctl=%b stall=%0d want 1100 0", ctl, stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         apply(bit'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0));
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_errors++; $display("FAIL rand_ctl cyc%0d: got %b want %b", i, ctl, exp_ctl);
         end
         tick();
         n_checks++;
         if ({stall_cnt_o, flush_cnt_o, wdog_err_o} !==
             {CW'(m_stall), CW'(m_flush), m_wdog}) begin
            n_errors++;
            $display("FAIL rand_regs cyc%0d: stall=%0d/%0d flush=%0d/%0d wdog=%b/%b (got/want)",
                     i, stall_cnt_o, m_stall, flush_cnt_o, m_flush, wdog_err_o, m_wdog);
         end
      end
      // Long hazard runs so the random phase also reaches the watchdog.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 15) != 0), ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 7) == 0));
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_errors++; $display("FAIL rand2_ctl cyc%0d: got %b want %b", i, ctl, exp_ctl);
         end
         tick();
         n_checks++;
         if ({stall_cnt_o, flush_cnt_o, wdog_err_o} !==
             {CW'(m_stall), CW'(m_flush), m_wdog}) begin
            n_errors++;
            $display("FAIL rand2_regs cyc%0d: stall=%0d/%0d flush=%0d/%0d wdog=%b/%b (got/want)",
                     i, stall_cnt_o, m_stall, flush_cnt_o, m_flush, wdog_err_o, m_wdog);
         end
      end
   endtask

   initial begin
      reset = 1'b1; hazard_i = 1'b0; redirect_i = 1'b0; freeze_i = 1'b0;
      test_reset();
      test_stall();
      test_flush();
      test_redirect_hazard();
      test_freeze();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
